// File: rtl/instruction_memory_ctrl.sv
// Instruction memory for the fetch stage: NOP-cleared after reset, loaded
// through a program port, read through a registered 1-cycle fetch port.
//
// Parameters: DATA_WIDTH, ADDR_WIDTH, DEPTH (<= 2**ADDR_WIDTH), NOP_WORD
// Ports:
//   clock, reset (async, active-low)
//   prog_we/prog_addr/prog_data  program-port write; prog_err = rejected write
//   fetch_req/fetch_addr         fetch request; fetch_ready = accepted
//   instr/instr_valid/addr_fault registered fetch result
//   mem_ready                    initialisation complete
// Optional macro IMEM_PARITY_EN adds per-word even parity with ports
//   parity_flip (in, inverts stored parity on write) and parity_err (out).

module instruction_memory_ctrl #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 10,
    parameter int                    DEPTH      = 31,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  prog_err,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic                  fetch_ready,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  addr_fault,
`ifdef IMEM_PARITY_EN
    input  logic                  parity_flip,
    output logic                  parity_err,
`endif
    output logic                  mem_ready
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_A  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    state_e                  state_q;
    logic [IDX_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   instr_q;
    logic                    instr_valid_q;
    logic                    addr_fault_q;
    logic                    prog_err_q;
    logic                    mem_ready_q;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    prog_in_range;
    logic                    fetch_in_range;
    logic [IDX_W-1:0]        prog_idx;
    logic [IDX_W-1:0]        fetch_idx;
    logic                    fetch_accept;
    logic [DATA_WIDTH-1:0]   rd_word;

    logic                    mem_we;
    logic [IDX_W-1:0]        mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // Compare with one extra bit so DEPTH == 2**ADDR_WIDTH still works.
    assign prog_in_range  = {1'b0, prog_addr} < DEPTH_A;
    assign fetch_in_range = {1'b0, fetch_addr} < DEPTH_A;
    assign prog_idx       = prog_addr[IDX_W-1:0];
    assign fetch_idx      = fetch_addr[IDX_W-1:0];

    // Writes win the port: a cycle with prog_we never accepts a fetch.
    assign fetch_ready  = (state_q == S_READY) && !prog_we;
    assign fetch_accept = fetch_req && fetch_ready;
    assign rd_word      = mem[fetch_idx];

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = cnt_q;
        mem_wdata = NOP_WORD;
        if (state_q == S_INIT) begin
            mem_we = 1'b1;
        end else if (prog_we && prog_in_range) begin
            mem_we    = 1'b1;
            mem_waddr = prog_idx;
            mem_wdata = prog_data;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic mem_wpar;
    logic rd_par;
    logic parity_err_q;

    // Even parity: stored bit makes the total count of ones even.
    always_comb begin
        mem_wpar = ^NOP_WORD;
        if (state_q != S_INIT) begin
            mem_wpar = (^prog_data) ^ parity_flip;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            par_mem[mem_waddr] <= mem_wpar;
        end
    end

    assign rd_par = par_mem[fetch_idx];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= fetch_accept && fetch_in_range &&
                            ((^rd_word) != rd_par);
        end
    end

    assign parity_err = parity_err_q;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= S_INIT;
            cnt_q         <= '0;
            instr_q       <= NOP_WORD;
            instr_valid_q <= 1'b0;
            addr_fault_q  <= 1'b0;
            prog_err_q    <= 1'b0;
            mem_ready_q   <= 1'b0;
        end else begin
            prog_err_q    <= prog_we &&
                             ((state_q == S_INIT) || !prog_in_range);
            instr_valid_q <= fetch_accept;
            addr_fault_q  <= fetch_accept && !fetch_in_range;
            if (fetch_accept) begin
                instr_q <= fetch_in_range ? rd_word : NOP_WORD;
            end
            unique case (state_q)
                S_INIT: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q     <= S_READY;
                        mem_ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_READY: begin
                    mem_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign addr_fault  = addr_fault_q;
    assign prog_err    = prog_err_q;
    assign mem_ready   = mem_ready_q;

endmodule

// File: tb/tb_instruction_memory_ctrl.sv
// Directed, table-driven bench for instruction_memory_ctrl (DEPTH=31).
// Inputs change 1 time unit after posedge; outputs sampled there too.

module tb_instruction_memory_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 31;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          prog_we = 1'b0;
    logic [AW-1:0] prog_addr = '0;
    logic [DW-1:0] prog_data = '0;
    logic          prog_err;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          fetch_ready;
    logic [DW-1:0] instr;
    logic          instr_valid;
    logic          addr_fault;
    logic          mem_ready;
`ifdef IMEM_PARITY_EN
    logic          parity_flip = 1'b0;
    logic          parity_err;
`endif

    instruction_memory_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH),
        .NOP_WORD  (32'h0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_err   (prog_err),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .instr      (instr),
        .instr_valid(instr_valid),
        .addr_fault (addr_fault),
`ifdef IMEM_PARITY_EN
        .parity_flip(parity_flip),
        .parity_err (parity_err),
`endif
        .mem_ready  (mem_ready)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic          we;
        logic [AW-1:0] paddr;
        logic [DW-1:0] pdata;
        logic          req;
        logic [AW-1:0] faddr;
        logic          fr;
        logic          valid;
        logic [DW-1:0] instr;
        logic          fault;
        logic          perr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, int pa, logic [31:0] pd,
                                logic req, int fa, logic fr, logic v,
                                logic [31:0] ins, logic f, logic pe);
        vec_t x;
        x.we = we; x.paddr = AW'(pa); x.pdata = pd;
        x.req = req; x.faddr = AW'(fa); x.fr = fr;
        x.valid = v; x.instr = ins; x.fault = f; x.perr = pe;
        return x;
    endfunction

    task automatic apply(input vec_t x, input int idx);
        prog_we    = x.we;
        prog_addr  = x.paddr;
        prog_data  = x.pdata;
        fetch_req  = x.req;
        fetch_addr = x.faddr;
        #1;
        chk($sformatf("v%0d.fetch_ready", idx), 32'(fetch_ready), 32'(x.fr));
        @(posedge clock); #1;
        chk($sformatf("v%0d.instr_valid", idx), 32'(instr_valid), 32'(x.valid));
        chk($sformatf("v%0d.instr", idx), instr, x.instr);
        chk($sformatf("v%0d.addr_fault", idx), 32'(addr_fault), 32'(x.fault));
        chk($sformatf("v%0d.prog_err", idx), 32'(prog_err), 32'(x.perr));
    endtask

    task automatic idle();
        prog_we   = 1'b0;
        fetch_req = 1'b0;
`ifdef IMEM_PARITY_EN
        parity_flip = 1'b0;
`endif
    endtask

    // Counts edges from now until mem_ready rises, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (!mem_ready && n < 200) begin
            @(posedge clock); #1;
            n++;
        end
    endtask

    int n;

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst.mem_ready", 32'(mem_ready), 32'd0);
        chk("rst.fetch_ready", 32'(fetch_ready), 32'd0);
        chk("rst.instr", instr, 32'h0);
        chk("rst.instr_valid", 32'(instr_valid), 32'd0);
        chk("rst.addr_fault", 32'(addr_fault), 32'd0);
        chk("rst.prog_err", 32'(prog_err), 32'd0);

        reset = 1'b1;
        wait_ready(n);
        chk("init.len", 32'(n), 32'd31);

        // we pa pdata req fa | fr valid instr fault perr
        vecs.push_back(mk(0, 0, 0, 1, 5, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h04221800, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h58600000, 0, 0, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h04221800, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 1, 32'h58600000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h58600000, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 31, 1, 1, 32'h0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 1023, 1, 1, 32'h0, 1, 0));
        vecs.push_back(mk(1, 40, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 32'h0, 0, 0));
        vecs.push_back(mk(1, 40, 32'hDEADBEEF, 0, 0, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(1, 41, 32'hCAFEF00D, 0, 0, 0, 0, 32'h0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 1, 8, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 9, 1, 1, 32'h0, 0, 0));
        vecs.push_back(mk(1, 3, 32'h12345678, 1, 3, 0, 0, 32'h0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 3, 1, 1, 32'h12345678, 0, 0));
        vecs.push_back(mk(1, 30, 32'hAAAA5555, 0, 0, 0, 0, 32'h12345678, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 30, 1, 1, 32'hAAAA5555, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, 32'h04221800, 0, 0));

        foreach (vecs[i]) apply(vecs[i], i);
        idle();

`ifdef IMEM_PARITY_EN
        parity_flip = 1'b1;
        prog_we = 1'b1; prog_addr = 10'd2; prog_data = 32'h00000007;
        @(posedge clock); #1;
        parity_flip = 1'b0; prog_we = 1'b0;
        fetch_req = 1'b1; fetch_addr = 10'd2;
        @(posedge clock); #1;
        fetch_req = 1'b0;
        chk("par.flip.valid", 32'(instr_valid), 32'd1);
        chk("par.flip.err", 32'(parity_err), 32'd1);
        prog_we = 1'b1; prog_addr = 10'd2; prog_data = 32'h00000007;
        @(posedge clock); #1;
        prog_we = 1'b0;
        fetch_req = 1'b1; fetch_addr = 10'd2;
        @(posedge clock); #1;
        fetch_req = 1'b0;
        chk("par.ok.err", 32'(parity_err), 32'd0);
        chk("par.ok.instr", instr, 32'h00000007);
        fetch_req = 1'b1; fetch_addr = 10'd31;
        @(posedge clock); #1;
        fetch_req = 1'b0;
        chk("par.oor.err", 32'(parity_err), 32'd0);
        chk("par.oor.fault", 32'(addr_fault), 32'd1);
`endif

        // Asynchronous reset from READY with non-reset outputs showing
        chk("pre_rst.mem_ready", 32'(mem_ready), 32'd1);
        reset = 1'b0;
        #2;
        chk("arst.mem_ready", 32'(mem_ready), 32'd0);
        chk("arst.instr", instr, 32'h0);
        chk("arst.fetch_ready", 32'(fetch_ready), 32'd0);
        #2;
        reset = 1'b1;

        // Nine quiet INIT cycles, then a write during INIT on the tenth
        repeat (9) @(posedge clock);
        #1;
        prog_we = 1'b1; prog_addr = 10'd4; prog_data = 32'h11111111;
        @(posedge clock); #1;
        prog_we = 1'b0;
        chk("init_wr.prog_err", 32'(prog_err), 32'd1);
        chk("init_wr.mem_ready", 32'(mem_ready), 32'd0);

        // Mid-INIT reset pulse clears the pending prog_err pulse at once
        reset = 1'b0;
        #1;
        chk("mid_rst.prog_err", 32'(prog_err), 32'd0);
        chk("mid_rst.mem_ready", 32'(mem_ready), 32'd0);
        #2;
        reset = 1'b1;
        wait_ready(n);
        chk("reinit.len", 32'(n), 32'd31);

        // INIT cleared previously written words
        fetch_req = 1'b1; fetch_addr = 10'd0;
        #1;
        chk("clr.fetch_ready", 32'(fetch_ready), 32'd1);
        @(posedge clock); #1;
        fetch_req = 1'b1; fetch_addr = 10'd4;
        chk("clr.addr0", instr, 32'h0);
        chk("clr.valid0", 32'(instr_valid), 32'd1);
        @(posedge clock); #1;
        fetch_req = 1'b0;
        chk("clr.addr4", instr, 32'h0);
        chk("clr.fault4", 32'(addr_fault), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
